// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings: opcodes, sequencer states, datapath select codes
// and trap causes. The decoder and datapath import the same constants.
package rv32i_pkg;

    // Base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Sequencer states; the encoding is visible on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Instruction classes the sequencer distinguishes
    typedef enum logic [3:0] {
        CL_ILLEGAL,
        CL_OP,
        CL_OPIMM,
        CL_LUI,
        CL_AUIPC,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LOAD,
        CL_STORE,
        CL_FENCE,
        CL_SYSTEM
    } op_class_t;

    // Next-PC source
    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [1:0] PC_SEL_ALU   = 2'd2;

    // Register write-back source
    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_UIMM = 2'd3;

    // Immediate format
    localparam logic [2:0] IMM_SEL_I = 3'd0;
    localparam logic [2:0] IMM_SEL_S = 3'd1;
    localparam logic [2:0] IMM_SEL_B = 3'd2;
    localparam logic [2:0] IMM_SEL_U = 3'd3;
    localparam logic [2:0] IMM_SEL_J = 3'd4;

    // Trap causes
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_ECALL   = 2'd3;

    // Map an opcode to its sequencing class; anything unlisted is illegal
    function automatic op_class_t classify(input logic [6:0] opc);
        op_class_t cls;
        case (opc)
            OPC_OP:     cls = CL_OP;
            OPC_OPIMM:  cls = CL_OPIMM;
            OPC_LUI:    cls = CL_LUI;
            OPC_AUIPC:  cls = CL_AUIPC;
            OPC_BRANCH: cls = CL_BRANCH;
            OPC_JAL:    cls = CL_JAL;
            OPC_JALR:   cls = CL_JALR;
            OPC_LOAD:   cls = CL_LOAD;
            OPC_STORE:  cls = CL_STORE;
            OPC_FENCE:  cls = CL_FENCE;
            OPC_SYSTEM: cls = CL_SYSTEM;
            default:    cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rv32i_mc_control_if.sv
// Shared memory port handshake between the control sequencer (master)
// and the memory subsystem (slave).
interface rv32i_mc_control_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles a memory request has been waiting. expire flags the last
// cycle the request may still complete; if mem_ready is absent on that
// cycle the sequencer traps.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    // Wait counter: clear has priority, otherwise count waiting cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (count_en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expire = (count_reg == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/rv32i_mc_control.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a
// trap sink, shared memory port handshake, wait timeout and instret.
module rv32i_mc_control
    import rv32i_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                opcode,
    input  logic [2:0]                fun3,
    input  logic                      br_taken,
    rv32i_mc_control_if.master        mem,
    output logic                      ir_we,
    output logic                      pc_we,
    output logic [1:0]                pc_sel,
    output logic                      alu_src_a,
    output logic                      alu_src_b,
    output logic [2:0]                imm_sel,
    output logic                      reg_we,
    output logic [1:0]                wb_sel,
    output logic                      trap,
    output logic [1:0]                trap_cause,
    output logic [2:0]                state,
    output logic [31:0]               instret
);

    state_t      state_reg, state_next;
    logic [1:0]  cause_reg, cause_next;
    logic [31:0] instret_reg;
    logic        run_reg;
    op_class_t   op_class;
    logic        mem_req_c, mem_we_c, mem_addr_sel_c;
    logic        wait_clear, wait_count_en, wait_expire;

    // fun3 is part of the decoder contract; every SYSTEM/FENCE variant is
    // sequenced identically, so the sequencer itself does not look at it.
    logic unused_fun3;
    assign unused_fun3 = ^fun3;

    assign op_class = classify(opcode);

    // A request is outstanding only in FETCH/MEM once running. The timer
    // enable is derived from state directly to keep it off the output path.
    assign wait_count_en = run_reg && ((state_reg == ST_FETCH) || (state_reg == ST_MEM))
                           && !mem.mem_ready;
    assign wait_clear    = !wait_count_en;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wait_clear),
        .count_en (wait_count_en),
        .expire   (wait_expire)
    );

    // Run flag: keeps every enable low while reset is held and until the
    // first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // State, trap cause and retired-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_FETCH;
            cause_reg   <= CAUSE_NONE;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
            if (pc_we) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    // Next-state and output decode from state and instruction class
    always_comb begin
        state_next     = state_reg;
        cause_next     = cause_reg;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_sel         = PC_SEL_PLUS4;
        alu_src_a      = 1'b0;
        alu_src_b      = 1'b0;
        imm_sel        = IMM_SEL_I;
        reg_we         = 1'b0;
        wb_sel         = WB_SEL_ALU;

        if (run_reg) begin
            // Operand and immediate selects are meaningful once IR is loaded
            if ((state_reg == ST_DECODE) || (state_reg == ST_EXEC) ||
                (state_reg == ST_MEM) || (state_reg == ST_WB)) begin
                case (op_class)
                    CL_STORE:          imm_sel = IMM_SEL_S;
                    CL_BRANCH:         imm_sel = IMM_SEL_B;
                    CL_LUI, CL_AUIPC:  imm_sel = IMM_SEL_U;
                    CL_JAL:            imm_sel = IMM_SEL_J;
                    default:           imm_sel = IMM_SEL_I;
                endcase
                alu_src_a = (op_class == CL_AUIPC) || (op_class == CL_JAL) ||
                            (op_class == CL_BRANCH);
                alu_src_b = !((op_class == CL_OP) || (op_class == CL_BRANCH));
            end

            case (state_reg)
                ST_FETCH: begin
                    mem_req_c = 1'b1;
                    if (mem.mem_ready) begin
                        ir_we      = 1'b1;
                        state_next = ST_DECODE;
                    end else if (wait_expire) begin
                        state_next = ST_TRAP;
                        cause_next = CAUSE_TIMEOUT;
                    end
                end

                ST_DECODE: begin
                    case (op_class)
                        CL_ILLEGAL: begin
                            state_next = ST_TRAP;
                            cause_next = CAUSE_ILLEGAL;
                        end
                        CL_SYSTEM: begin
                            state_next = ST_TRAP;
                            cause_next = CAUSE_ECALL;
                        end
                        default: state_next = ST_EXEC;
                    endcase
                end

                ST_EXEC: begin
                    case (op_class)
                        CL_BRANCH: begin
                            pc_we      = 1'b1;
                            pc_sel     = br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                            state_next = ST_FETCH;
                        end
                        CL_FENCE: begin
                            pc_we      = 1'b1;
                            state_next = ST_FETCH;
                        end
                        CL_LOAD, CL_STORE: state_next = ST_MEM;
                        default:           state_next = ST_WB;
                    endcase
                end

                ST_MEM: begin
                    mem_req_c      = 1'b1;
                    mem_addr_sel_c = 1'b1;
                    mem_we_c       = (op_class == CL_STORE);
                    if (mem.mem_ready) begin
                        if (op_class == CL_STORE) begin
                            pc_we      = 1'b1;
                            state_next = ST_FETCH;
                        end else begin
                            state_next = ST_WB;
                        end
                    end else if (wait_expire) begin
                        state_next = ST_TRAP;
                        cause_next = CAUSE_TIMEOUT;
                    end
                end

                ST_WB: begin
                    reg_we     = 1'b1;
                    pc_we      = 1'b1;
                    state_next = ST_FETCH;
                    case (op_class)
                        CL_LOAD:         wb_sel = WB_SEL_MEM;
                        CL_JAL, CL_JALR: wb_sel = WB_SEL_PC4;
                        CL_LUI:          wb_sel = WB_SEL_UIMM;
                        default:         wb_sel = WB_SEL_ALU;
                    endcase
                    case (op_class)
                        CL_JAL:  pc_sel = PC_SEL_IMM;
                        CL_JALR: pc_sel = PC_SEL_ALU;
                        default: pc_sel = PC_SEL_PLUS4;
                    endcase
                end

                ST_TRAP: begin
                    // Terminal: everything stays low until reset
                end

                default: begin
                    state_next = ST_FETCH;
                end
            endcase
        end
    end

    assign mem.mem_req      = mem_req_c;
    assign mem.mem_we       = mem_we_c;
    assign mem.mem_addr_sel = mem_addr_sel_c;

    assign state      = state_reg;
    assign trap       = (state_reg == ST_TRAP);
    assign trap_cause = cause_reg;
    assign instret    = instret_reg;

endmodule

// File: doc/rv32i_mc_control.md
# rv32i_mc_control

Multi-cycle control sequencer for the RV32I core. Steps one instruction at a time through fetch, decode, execute, memory and write-back, driving datapath enables and mux selects from the opcode/fun3 fields produced by the instruction decoder. Owns the single shared memory port handshake, a memory-wait timeout, and the retired-instruction counter. Traps on illegal opcodes, ECALL/EBREAK and memory timeout.

## Interface
- MEM_TIMEOUT, 16: max cycles a memory request may wait for `mem_ready` before a trap (≥2).
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  decoder opcode; valid from DECODE onward (IR stable).
- fun3  in  3  decoder fun3; valid with opcode.
- br_taken  in  1  branch comparator result; sampled in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request, held until `mem_ready` or trap.
- mem_we  out  1  store request (with `mem_req`).
- mem_addr_sel  out  1  0 = PC, 1 = ALU result.
- ir_we  out  1  load IR (FETCH and `mem_ready`).
- pc_we  out  1  update PC; asserted exactly once per retired instruction.
- pc_sel  out  2  0 = PC+4, 1 = PC+imm (branch taken/JAL), 2 = ALU (JALR, bit0 cleared by datapath).
- alu_src_a  out  1  0 = rs1, 1 = PC.
- alu_src_b  out  1  0 = rs2, 1 = immediate.
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- reg_we  out  1  register file write.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = U-immediate.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout, 3 = ECALL/EBREAK.
- state  out  3  current FSM state (debug).
- instret  out  32  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are decoded combinationally from state and opcode (Moore w.r.t. state).
- FETCH: `mem_req`=1, `mem_addr_sel`=0. On `mem_ready`: `ir_we`=1 → DECODE.
- DECODE: classify opcode. Unknown opcode → TRAP, cause 1. SYSTEM (1110011) → TRAP, cause 3. Otherwise → EXEC.
- EXEC by class:
  - OP / OP-IMM / LUI / AUIPC → WB.
  - BRANCH: `pc_we`=1, `pc_sel`=`br_taken`?1:0 → FETCH.
  - JAL / JALR → WB.
  - LOAD / STORE → MEM.
  - FENCE: `pc_we`=1, `pc_sel`=0 → FETCH (no-op).
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=STORE. On `mem_ready`: LOAD → WB; STORE → `pc_we`=1, `pc_sel`=0 → FETCH.
- WB: `reg_we`=1, `pc_we`=1 → FETCH. `wb_sel`: LOAD 1, JAL/JALR 2, LUI 3, else 0. `pc_sel`: JAL 1, JALR 2, else 0.
- Selects: `imm_sel` by format (OP-IMM/LOAD/JALR I, STORE S, BRANCH B, LUI/AUIPC U, JAL J). `alu_src_a`=1 for AUIPC/JAL/BRANCH target. `alu_src_b`=1 for all except OP and BRANCH compare.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments each cycle `mem_req` is high without `mem_ready`. Reaching MEM_TIMEOUT → TRAP, cause 2. `mem_ready` on the final counted cycle wins over the timeout.
- TRAP: all enables low and `trap`=1. Held until reset; no exit.
- `instret` +1 on every cycle with `pc_we`=1. It wraps modulo 2^32.
- `mem_ready` outside FETCH/MEM is ignored.

## Timing
- Reset (async assert, sync-released use): state=FETCH, `instret`=0, wait counter=0, `trap`=0, `trap_cause`=0.
- During reset, all enables are 0. `mem_req` rises in the first cycle after reset release.
- Cycles per instruction, with 1-cycle `mem_ready`:
  - Branch/FENCE: 3.
  - ALU/LUI/AUIPC/JAL/JALR: 4.
  - Store: 4.
  - Load: 5.
  - Each extra memory wait cycle adds 1.
- `ir_we` and `mem_ready` are coincident. The IR holds the new value from the DECODE cycle.
- Reset asserted mid-instruction aborts immediately. No PC/register writes occur after assertion.

## Structure
- Shared package `rv32i_pkg`: opcode constants, state encoding, `pc_sel`/`wb_sel`/`imm_sel`/`trap_cause` encodings. The decoder and datapath reuse these.
- One sub-module `mem_wait_timer` (counter, clear, expire flag, parameter MEM_TIMEOUT). The FSM, output decode and `instret` live in the top.

## Test plan
- ADDI (0010011), `mem_ready` 1 cycle after each request → states FETCH, DECODE, EXEC, WB; `reg_we`=1 and `pc_we`=1 only in WB, `wb_sel`=0, `instret`=1.
- BEQ with `br_taken`=1, then with 0 → `pc_we` in EXEC with `pc_sel`=1, then 0; no `reg_we`; 3 cycles each.
- LW with `mem_ready` delayed 3 cycles in MEM → `mem_req`, `mem_addr_sel`=1 held 4 cycles; WB has `wb_sel`=1; total 8 cycles.
- Opcode 0000000, then reset → TRAP with cause 1; `trap`=1 with no enables for 20 cycles; `rst_n`=0 returns state=FETCH and `instret`=0 asynchronously.
- MEM_TIMEOUT=4, `mem_ready` never asserted in FETCH → TRAP with cause 2 after 4 request cycles; `mem_ready` on the 4th cycle instead completes the fetch normally.
- JALR, then SW → JALR: WB with `wb_sel`=2, `pc_sel`=2, `imm_sel`=0. SW: `mem_we`=1, `imm_sel`=1, `pc_we` on `mem_ready`, `reg_we` never set.
